// File: rtl/checkbits_if.sv
// Bundle between the pad-side checkpoint bus and checkbits_monitor.
// checkbits flows master->slave; everything else is the monitor's report.
interface checkbits_if;
   // event_valid is a one-cycle strobe qualifying event_code; there is no ready,
   // a strobe is never held or repeated and the sink must take it on that cycle.
   logic [15:0] checkbits;
   logic        event_valid;
   logic [15:0] event_code;
   logic [1:0]  block_started;
   logic [1:0]  block_passed;
   logic        done;
   logic        pass;
   logic        fail;
   logic        timeout;
   logic [2:0]  err_code;

   modport master (
      output checkbits,
      input  event_valid, event_code, block_started, block_passed,
      input  done, pass, fail, timeout, err_code
   );

   modport slave (
      input  checkbits,
      output event_valid, event_code, block_started, block_passed,
      output done, pass, fail, timeout, err_code
   );
endinterface

// File: rtl/checkbits_monitor.sv
// Storage self-test checkpoint monitor: synchronizer, stability filter, code decode, ordering FSM.
// Build macro CHECKBITS_TIMEOUT_EN adds a no-verdict watchdog that fails with err_code 3.
module checkbits_monitor #(
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic       clock,
   input  logic       resetb,
   checkbits_if.slave mon,
   output logic [2:0] dbg_state
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RUN0   = 3'd1,
      WAIT1  = 3'd2,
      RUN1   = 3'd3,
      PASSED = 3'd4,
      FAILED = 3'd5
   } state_t;

   localparam logic [7:0]  STABLE_LAST = 8'(STABLE_CYCLES - 1);
   localparam logic [15:0] CODE_START0 = 16'hA040;
   localparam logic [15:0] CODE_START1 = 16'hA020;
   localparam logic [15:0] CODE_PASS0  = 16'hAB41;
   localparam logic [15:0] CODE_PASS1  = 16'hAB21;
   localparam logic [15:0] CODE_FAIL0  = 16'hAB40;
   localparam logic [15:0] CODE_FAIL1  = 16'hAB20;

   logic [15:0] sync1_q, sync2_q, prev_q, acc_q, acc_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        changed, accept;
   logic        is_s0, is_s1, is_p0, is_p1, is_f0, is_f1, legal, evt;
   logic        terminal, advance, blk_fail, code_verdict, tmo_hit;

   state_t      state_q;
   logic        ev_valid_q, tmo_q;
   logic [15:0] ev_code_q;
   logic [1:0]  started_q, passed_q;
   logic [2:0]  err_q;

   // acc_q remembers the last accepted word so a bus returning to it after a
   // discarded glitch does not produce a second event.
   always_comb begin
      changed = (sync2_q != prev_q);
      cnt_d   = changed ? 8'd0 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);
      accept  = (cnt_d == STABLE_LAST) && (changed || (cnt_d != cnt_q)) && (sync2_q != acc_q);
      acc_d   = accept ? sync2_q : acc_q;
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
      end else begin
         sync1_q <= mon.checkbits;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      is_s0        = (sync2_q == CODE_START0);
      is_s1        = (sync2_q == CODE_START1);
      is_p0        = (sync2_q == CODE_PASS0);
      is_p1        = (sync2_q == CODE_PASS1);
      is_f0        = (sync2_q == CODE_FAIL0);
      is_f1        = (sync2_q == CODE_FAIL1);
      legal        = is_s0 | is_s1 | is_p0 | is_p1 | is_f0 | is_f1;
      evt          = accept && legal;
      terminal     = (state_q == PASSED) || (state_q == FAILED);
      advance      = ((state_q == IDLE) && is_s0) || ((state_q == RUN0) && is_p0) ||
                     ((state_q == WAIT1) && is_s1);
      blk_fail     = ((state_q == RUN0) && is_f0) || ((state_q == RUN1) && is_f1);
      code_verdict = evt && !terminal && !advance;
   end

`ifdef CHECKBITS_TIMEOUT_EN
   localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
   logic [23:0] tmo_cnt_q, tmo_cnt_d;

   always_comb begin
      tmo_cnt_d = terminal ? tmo_cnt_q : tmo_cnt_q + 24'd1;
      tmo_hit   = !terminal && (tmo_cnt_q == TMO_LAST);
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) tmo_cnt_q <= '0;
      else         tmo_cnt_q <= tmo_cnt_d;
   end
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = ^24'(TIMEOUT_CYCLES);
   assign tmo_hit        = 1'b0;
`endif

   // A code that reaches a verdict on the watchdog's edge wins; a non-verdict
   // code still records its progress before the timeout takes the FSM to FAILED.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q    <= IDLE;
         ev_valid_q <= 1'b0;
         ev_code_q  <= '0;
         started_q  <= '0;
         passed_q   <= '0;
         err_q      <= '0;
         tmo_q      <= 1'b0;
      end else begin
         ev_valid_q <= evt;
         if (evt) ev_code_q <= sync2_q;
         if (evt && !terminal) begin
            if (advance) begin
               case (state_q)
                  IDLE:    begin state_q <= RUN0;  started_q[0] <= 1'b1; end
                  RUN0:    begin state_q <= WAIT1; passed_q[0]  <= 1'b1; end
                  default: begin state_q <= RUN1;  started_q[1] <= 1'b1; end
               endcase
            end else if ((state_q == RUN1) && is_p1) begin
               state_q     <= PASSED;
               passed_q[1] <= 1'b1;
            end else begin
               state_q <= FAILED;
               err_q   <= blk_fail ? 3'd1 : 3'd2;
            end
         end
         if (tmo_hit && !code_verdict) begin
            state_q <= FAILED;
            err_q   <= 3'd3;
            tmo_q   <= 1'b1;
         end
      end
   end

   assign mon.event_valid   = ev_valid_q;
   assign mon.event_code    = ev_code_q;
   assign mon.block_started = started_q;
   assign mon.block_passed  = passed_q;
   assign mon.done          = terminal;
   assign mon.pass          = (state_q == PASSED);
   assign mon.fail          = (state_q == FAILED);
   assign mon.timeout       = tmo_q;
   assign mon.err_code      = err_q;
   assign dbg_state         = state_q;
endmodule

// File: tb/tb_checkbits_monitor.sv
// Directed and randomized bench for checkbits_monitor against a code-sequence reference model.
`timescale 1ns/1ps
module tb_checkbits_monitor;
   localparam int STABLE = 4;
   localparam int TMO    = 500;
   localparam logic [15:0] S0 = 16'hA040, S1 = 16'hA020, P0 = 16'hAB41;
   localparam logic [15:0] P1 = 16'hAB21, F0 = 16'hAB40, F1 = 16'hAB20;

   // ---------------- clock / reset ----------------
   logic       clk    = 1'b0;
   logic       resetb = 1'b0;
   logic [2:0] dbg_state;
   int         cyc    = 0;

   checkbits_if bus_if ();

   checkbits_monitor #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
      .clock    (clk),
      .resetb   (resetb),
      .mon      (bus_if),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard / model state ----------------
   logic [15:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          n_ev = 0;
   int          last_ev_cyc = -1;

   logic [15:0] golden [4]     = '{S0, P0, S1, P1};
   logic [15:0] legal_pool [6] = '{S0, S1, P0, P1, F0, F1};
   logic [15:0] junk_pool [6]  = '{16'h0000, 16'h1234, 16'hA041, 16'hAB42, 16'hFFFF, 16'hA000};

   int          m_step;
   bit          m_fail;
   int          m_err;
   logic [1:0]  m_started, m_passed;
   logic [15:0] m_last;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // The model works on the sequence of accepted codes: progress through the
   // golden order, block fail of the running block, anything else is ordering.
   task automatic model_reset();
      m_step = 0; m_fail = 0; m_err = 0;
      m_started = 2'b00; m_passed = 2'b00; m_last = 16'h0000;
      exp_q.delete();
   endtask

   task automatic model_feed(input logic [15:0] w);
      if (w == m_last) return;
      m_last = w;
      if (!(w inside {S0, S1, P0, P1, F0, F1})) return;
      exp_q.push_back(w);
      if (m_fail || m_step == 4) return;
      if (w == golden[m_step]) begin
         if (m_step % 2 == 0) m_started[m_step/2] = 1'b1;
         else                 m_passed[m_step/2]  = 1'b1;
         m_step++;
      end else if ((m_step == 1 && w == F0) || (m_step == 3 && w == F1)) begin
         m_fail = 1; m_err = 1;
      end else begin
         m_fail = 1; m_err = 2;
      end
   endtask

   // ---------------- event monitor ----------------
   always @(negedge clk) begin
      if (resetb && bus_if.event_valid) begin
         n_ev++;
         last_ev_cyc = cyc;
         if (exp_q.size() == 0)
            check("event_unexpected", 32'(bus_if.event_code), 32'h1_0000);
         else
            check("event_code", 32'(bus_if.event_code), 32'(exp_q.pop_front()));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [15:0] w, input int hold);
      if (hold >= STABLE) model_feed(w);
      bus_if.checkbits = w;
      repeat (hold) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetb = 1'b0;
      bus_if.checkbits = 16'h0000;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetb = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ev_valid"}, 32'(bus_if.event_valid),   0);
      check({tag, "_ev_code"},  32'(bus_if.event_code),    0);
      check({tag, "_started"},  32'(bus_if.block_started), 0);
      check({tag, "_passed"},   32'(bus_if.block_passed),  0);
      check({tag, "_done"},     32'(bus_if.done),          0);
      check({tag, "_pass"},     32'(bus_if.pass),          0);
      check({tag, "_fail"},     32'(bus_if.fail),          0);
      check({tag, "_timeout"},  32'(bus_if.timeout),       0);
      check({tag, "_err"},      32'(bus_if.err_code),      0);
   endtask

   task automatic end_check(input string tag);
      check({tag, "_started"}, 32'(bus_if.block_started), 32'(m_started));
      check({tag, "_passed"},  32'(bus_if.block_passed),  32'(m_passed));
      check({tag, "_done"},    32'(bus_if.done),          32'(m_fail || m_step == 4));
      check({tag, "_pass"},    32'(bus_if.pass),          32'(!m_fail && m_step == 4));
      check({tag, "_fail"},    32'(bus_if.fail),          32'(m_fail));
      check({tag, "_err"},     32'(bus_if.err_code),      32'(m_fail ? m_err : 0));
      check({tag, "_timeout"}, 32'(bus_if.timeout),       0);
      check({tag, "_pending"}, 32'(exp_q.size()),         0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int ev0, chg, n, r, h;
      logic [15:0] w, cur;

      bus_if.checkbits = 16'h0000;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");

      // full pass sequence
      do_reset();
      ev0 = n_ev;
      send(S0, 10); send(P0, 10); send(S1, 10); send(P1, 10);
      repeat (4) @(posedge clk); #1;
      end_check("pass_seq");
      check("pass_seq_events", 32'(n_ev - ev0), 4);

      // block0 fail, then a code after the verdict
      do_reset();
      send(S0, 10); send(F0, 10); send(S1, 10);
      repeat (4) @(posedge clk); #1;
      end_check("blk0_fail");

      // glitch filter and acceptance latency
      do_reset();
      ev0 = n_ev;
      send(S0, 3); send(16'h0000, 10);
      check("glitch_events", 32'(n_ev - ev0), 0);
      check("glitch_started", 32'(bus_if.block_started), 0);
      chg = cyc;
      send(S0, 10);
      check("latency", 32'(last_ev_cyc - chg), 6);
      end_check("glitch");

      // ordering error: START1 skipped
      do_reset();
      send(S0, 10); send(P0, 10); send(P1, 10);
      repeat (4) @(posedge clk); #1;
      end_check("order_err");

      // watchdog: only START0 after reset release
      resetb = 1'b0;
      bus_if.checkbits = 16'h0000;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetb = 1'b1;
      @(posedge clk); #1;
      send(S0, TMO - 2);
      check("tmo_early_timeout", 32'(bus_if.timeout), 0);
      check("tmo_early_done", 32'(bus_if.done), 0);
      @(posedge clk); #1;
`ifdef CHECKBITS_TIMEOUT_EN
      check("tmo_timeout", 32'(bus_if.timeout), 1);
      check("tmo_err", 32'(bus_if.err_code), 3);
      check("tmo_fail", 32'(bus_if.fail), 1);
      check("tmo_done", 32'(bus_if.done), 1);
      check("tmo_started", 32'(bus_if.block_started), 1);
`else
      check("tmo_off_done", 32'(bus_if.done), 0);
      check("tmo_off_timeout", 32'(bus_if.timeout), 0);
      repeat (100) @(posedge clk); #1;
      check("tmo_off_done_late", 32'(bus_if.done), 0);
      check("tmo_off_started", 32'(bus_if.block_started), 1);
`endif
      check("tmo_pending", 32'(exp_q.size()), 0);

      // reset while block1 runs
      do_reset();
      send(S0, 10); send(P0, 10); send(S1, 10);
      end_check("run1");
      @(negedge clk);
      resetb = 1'b0;
      bus_if.checkbits = P1;
      #1;
      check_zero("mid_reset");
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetb = 1'b1;
      model_feed(P1);
      repeat (10) @(posedge clk); #1;
      end_check("after_reset");

      // randomized code streams with glitches
      for (int ep = 0; ep < 12; ep++) begin
         do_reset();
         cur = 16'h0000;
         n = $urandom_range(3, 8);
         for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 9);
            if (r < 4 && m_step < 4) w = golden[m_step];
            else if (r < 7)          w = legal_pool[$urandom_range(0, 5)];
            else                     w = junk_pool[$urandom_range(0, 5)];
            if (w == cur) w = w ^ 16'h0100;
            h = (k == n - 1) ? 12 : $urandom_range(1, 8);
            send(w, h);
            cur = w;
         end
         repeat (4) @(posedge clk); #1;
         end_check($sformatf("rand%0d", ep));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/checkbits_monitor.md
# checkbits_monitor

Synthesizable monitor for the 16-bit checkpoint word that management firmware drives on `mprj_io[31:16]` during the storage memory self-test. It filters glitches, decodes start/pass/fail codes for storage block0 and block1, enforces test ordering, and reports a sticky verdict. It sits directly downstream of the pad-side checkbits bus. It replaces ad-hoc simulation-only decoding on emulation and FPGA builds.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical samples required before a word is accepted (range 1..255).
- `TIMEOUT_CYCLES`, 100000: cycles after reset release without a verdict before timeout (range 1..2^24-1).
- `clock`  in  1  single clock for all logic.
- `resetb`  in  1  asynchronous, active-low reset.
- `checkbits`  in  16  raw checkpoint word from `mprj_io[31:16]`; asynchronous to firmware writes, sampled on `clock`.
- `event_valid`  out  1  one-cycle strobe when an accepted word decodes to a legal code.
- `event_code`  out  16  accepted word, valid with `event_valid`.
- `block_started`  out  2  sticky; bit n set on start of block n.
- `block_passed`  out  2  sticky; bit n set on pass of block n.
- `done`  out  1  sticky; verdict reached.
- `pass`  out  1  sticky; all blocks passed.
- `fail`  out  1  sticky; fail code, ordering error, or timeout.
- `timeout`  out  1  sticky; timeout cause of `fail`.
- `err_code`  out  3  cause: 0 none, 1 block fail code, 2 ordering error, 3 timeout.

## Operation
- Input path: two-flop synchronizer on `checkbits`, then a stability counter (8 bits). The counter resets to 0 when the synchronized word differs from the previous sample, otherwise saturates. The word is accepted once, when the counter reaches `STABLE_CYCLES-1`. A word held indefinitely is never re-accepted.
- Decoding of an accepted word W:
  - W == 0xA040 → START0; W == 0xA020 → START1.
  - W == 0xAB41 → PASS0; W == 0xAB21 → PASS1.
  - W == 0xAB40 → FAIL0; W == 0xAB20 → FAIL1.
  - Any other value is ignored: no strobe, no state change.
- FSM states: IDLE, RUN0, WAIT1, RUN1, PASSED, FAILED.
  - IDLE: START0 → RUN0.
  - RUN0: PASS0 → WAIT1; FAIL0 → FAILED (err 1).
  - WAIT1: START1 → RUN1.
  - RUN1: PASS1 → PASSED; FAIL1 → FAILED (err 1).
  - Any other legal code in IDLE, RUN0, WAIT1 or RUN1 is an ordering error → FAILED (err 2). This includes a repeat START0 or a PASS/FAIL for a block that is not running.
  - PASSED and FAILED are terminal until reset. Later codes still strobe `event_valid` but change nothing.
- Outputs: `done` = PASSED or FAILED. `pass` = PASSED. `fail` = FAILED.
- Reset values: all outputs 0; `event_code` 0; FSM IDLE; counters 0.

## Timing
- Latency from a `checkbits` change to `event_valid`: 2 cycles of synchronizer plus `STABLE_CYCLES` cycles. With default parameters, the strobe fires 6 cycles after the change.
- FSM outputs update on the same edge that raises `event_valid`.
- A change shorter than `STABLE_CYCLES` samples is discarded. The previously accepted word is not re-accepted if the bus returns to it.
- A timeout and a legal code in the same cycle: the code is processed first. If it yields a verdict, timeout is suppressed.
- Asserting `resetb` mid-test clears everything immediately. After release, the monitor requires START0 again.

## Configuration
- `CHECKBITS_TIMEOUT_EN` defined:
  - A 24-bit cycle counter runs from reset release while `done`=0.
  - At `TIMEOUT_CYCLES` the FSM enters FAILED with `timeout`=1 and err 3.
  - The counter freezes once `done` is set.
- Undefined: no counter is built, `timeout` is tied to 0, and err 3 never occurs.

## Test plan
- Pass sequence: drive 0xA040, 0xAB41, 0xA020, 0xAB21, each held 10 cycles → four `event_valid` strobes, `block_passed`=2'b11, `pass`=1, `done`=1, `err_code`=0.
- Block0 fail: 0xA040 then 0xAB40 → `fail`=1, `err_code`=1, `block_passed`=0. A following 0xA020 strobes but the state stays FAILED.
- Glitch filter: hold 0xA040 for 3 cycles, then 0x0000 → no strobe, FSM IDLE. Hold 0xA040 for 4 cycles → strobe 6 cycles after the change.
- Ordering error: 0xA040, 0xAB41, 0xAB21 (START1 skipped) → `fail`=1, `err_code`=2, `block_started`=2'b01.
- Timeout (macro on, `TIMEOUT_CYCLES`=500): only 0xA040 is driven → `timeout`=1, `err_code`=3 exactly 500 cycles after reset release. With the macro off, the same stimulus leaves `done`=0 indefinitely.
- Reset mid-test: pulse `resetb` low while in RUN1 → all outputs 0 asynchronously. After release, 0xAB21 gives `err_code`=2.
